// File: rtl/seq_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0]   prem_q, prem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    // The partial remainder never exceeds the divisor, so its top bit is
    // implicitly zero and only the WIDTH+1-bit trial operand carries it.
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_sub_b;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH+1:0]   w_borrow;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_prem_next;

    assign w_trial     = {prem_q, dvd_q[WIDTH-1]};
    assign w_sub_b     = {1'b0, dsr_q};
    assign w_borrow[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_sub
            assign w_borrow[gi+1] = (~w_trial[gi] & w_sub_b[gi])
                                  | (~(w_trial[gi] ^ w_sub_b[gi]) & w_borrow[gi]);
            if (gi < WIDTH) begin : g_diff
                assign w_diff[gi] = w_trial[gi] ^ w_sub_b[gi] ^ w_borrow[gi];
            end
        end
    endgenerate

    assign w_qbit      = ~w_borrow[WIDTH+1];
    assign w_prem_next = w_qbit ? w_diff : w_trial[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        prem_d      = prem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d  = dividend;
                    dsr_d  = divisor;
                    prem_d = '0;
                    cnt_d  = CNT_W'(WIDTH);
                    dbz_d  = 1'b0;
                    if (divisor == '0) begin
                        state_d     = S_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Quotient bits enter the dividend register from the LSB end.
                prem_d = w_prem_next;
                dvd_d  = {dvd_q[WIDTH-2:0], w_qbit};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = S_DONE;
                    quotient_d  = {dvd_q[WIDTH-2:0], w_qbit};
                    remainder_d = w_prem_next;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dsr_q       <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            prem_q      <= prem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // lat counts cycles from the accepting edge to the end of the done cycle.
    task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int inject_at, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = WIDTH'($urandom); divisor = WIDTH'($urandom);
        lat = -1; bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = i + 1;
                break;
            end
            if (i == inject_at) begin
                start = 1'b1; dividend = 8'd50; divisor = 8'd4;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            check("done_one_cycle", done, 0);
        end
    endtask

    task automatic do_case(input string tag, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input int inj);
        int lat, bcnt;
        longint eq, er, ez, elat, ebusy;
        if (b == 0) begin
            eq = (1 << WIDTH) - 1; er = a; ez = 1; elat = 1; ebusy = 0;
        end else begin
            eq = a / b; er = a % b; ez = 0; elat = WIDTH + 1; ebusy = WIDTH;
        end
        run_div(a, b, inj, lat, bcnt);
        check({tag, "_lat"},  lat,         elat);
        check({tag, "_busy"}, bcnt,        ebusy);
        check({tag, "_q"},    quotient,    eq);
        check({tag, "_r"},    remainder,   er);
        check({tag, "_dbz"},  div_by_zero, ez);
    endtask

    initial begin
        int rises[$];
        logic prev;
        int done_seen;
        logic [WIDTH-1:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q",    quotient, 0);
        check("rst_r",    remainder, 0);
        check("rst_dbz",  div_by_zero, 0);
        @(negedge clk); rst_n = 1'b1;

        do_case("d100_7",   8'd100, 8'd7,   -1);
        do_case("d255_1",   8'd255, 8'd1,   -1);
        do_case("d0_5",     8'd0,   8'd5,   -1);
        do_case("d5_9",     8'd5,   8'd9,   -1);
        do_case("d255_255", 8'd255, 8'd255, -1);
        do_case("d13_0",    8'd13,  8'd0,   -1);
        do_case("d20_3",    8'd20,  8'd3,   -1);
        do_case("inject",   8'd100, 8'd7,   3);

        // Start held high: accepts must be spaced WIDTH+2 cycles apart.
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        prev = busy;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (busy && !prev) rises.push_back(i);
            prev = busy;
        end
        start = 1'b0;
        check("held_rises", rises.size() >= 3, 1);
        for (int j = 1; j < rises.size(); j++)
            check("held_gap", rises[j] - rises[j-1], WIDTH + 2);
        repeat (12) @(posedge clk);
        #1;
        check("held_q", quotient, 14);

        do_case("pre_rst", 8'd20, 8'd3, -1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_q",    quotient, 0);
        check("mid_rst_r",    remainder, 0);
        check("mid_rst_dbz",  div_by_zero, 0);
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("mid_rst_no_done", done_seen, 0);
        do_case("post_rst", 8'd200, 8'd3, -1);

        for (int n = 0; n < 1000; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
            do_case("rand", ra, rb, -1);
            check("rand_ident", longint'(quotient) * rb + remainder, ra);
            check("rand_rem_lt", remainder < rb, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
